alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- EX-stage execute unit: registered ALU_OP/funct decode,
// single-cycle integer ops, and an iterative multiply/divide engine that
// owns the HI/LO registers.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   In_Valid        : op present; accepted only while the engine is idle
//   ALU_OP          : 00 add, 01 sub, 10 decode Function_Field, 11 illegal
//   Function_Field  : R-type funct
//   Operand_A/B     : rs/rt, dividend/divisor, multiplicand/multiplier
//   Result, Zero    : registered result and (Result == 0)
//   Out_Valid       : one-cycle pulse qualifying Result/Zero/Error
//   Busy            : multiply/divide in flight (stall request upstream)
//   Error           : illegal ALU_OP/funct
//
// Build option: define ALU_SIGNED_MD_EN to add signed mult (011000) and
// div (011010). They run on operand magnitudes through the same engine and
// get their signs fixed on the final step.
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  input  logic [1:0]       ALU_OP,
  input  logic [5:0]       Function_Field,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             Error
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  state_t state, state_nxt;

  // hi_q/lo_q double as the iteration working registers; HI/LO are only
  // observable (mfhi/mflo) while idle, so nothing sees the partial values.
  logic [WIDTH-1:0] hi_q, lo_q, md_q;
  logic [CNT_W-1:0] cnt;
  logic             last;

  logic [WIDTH-1:0] dec_res;
  logic             dec_err, dec_mul, dec_div;
  logic [WIDTH-1:0] ld_a, ld_b;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

`ifdef ALU_SIGNED_MD_EN
  logic dec_sgn, sgn_q, neg_q, neg_r;
`endif

  assign Busy = (state != S_IDLE);
  assign last = (cnt == CNT_W'(1));

  // ---------------- decode ----------------
  always_comb begin
    dec_res = '0;
    dec_err = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
`ifdef ALU_SIGNED_MD_EN
    dec_sgn = 1'b0;
`endif
    case (ALU_OP)
      2'b00: dec_res = Operand_A + Operand_B;
      2'b01: dec_res = Operand_A - Operand_B;
      2'b10: begin
        case (Function_Field)
          6'b100000: dec_res = Operand_A + Operand_B;
          6'b100010: dec_res = Operand_A - Operand_B;
          6'b100100: dec_res = Operand_A & Operand_B;
          6'b100101: dec_res = Operand_A | Operand_B;
          6'b100111: dec_res = ~(Operand_A | Operand_B);
          6'b101010: dec_res = {{(WIDTH-1){1'b0}}, ($signed(Operand_A) < $signed(Operand_B))};
          6'b010000: dec_res = hi_q;
          6'b010010: dec_res = lo_q;
          6'b011001: dec_mul = 1'b1;
          6'b011011: dec_div = 1'b1;
`ifdef ALU_SIGNED_MD_EN
          6'b011000: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
          6'b011010: begin dec_div = 1'b1; dec_sgn = 1'b1; end
`endif
          default:   dec_err = 1'b1;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

`ifdef ALU_SIGNED_MD_EN
  assign ld_a = (dec_sgn && Operand_A[WIDTH-1]) ? -Operand_A : Operand_A;
  assign ld_b = (dec_sgn && Operand_B[WIDTH-1]) ? -Operand_B : Operand_B;
`else
  assign ld_a = Operand_A;
  assign ld_b = Operand_B;
`endif

  // ---------------- one iteration step ----------------
  // multiply: {hi,lo} shift-add, multiplier consumed from lo[0]
  // divide:   restoring; remainder in hi, dividend shifts out of lo while
  //           quotient bits shift in. Divisor 0 yields all-ones / dividend.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, md_q};

  always_comb begin
    if (state == S_MUL) begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
    fin_hi = step_hi;
    fin_lo = step_lo;
`ifdef ALU_SIGNED_MD_EN
    if (sgn_q) begin
      if (state == S_MUL) begin
        if (neg_q) {fin_hi, fin_lo} = -{step_hi, step_lo};
      end else begin
        // divide-by-zero keeps the all-ones quotient unsigned-looking
        if (neg_q && md_q != '0) fin_lo = -step_lo;
        if (neg_r)               fin_hi = -step_hi;
      end
    end
`endif
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (In_Valid && dec_mul)      state_nxt = S_MUL;
        else if (In_Valid && dec_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath / outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      Result    <= '0;
      Zero      <= 1'b1;
      Out_Valid <= 1'b0;
      Error     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      md_q      <= '0;
      cnt       <= '0;
`ifdef ALU_SIGNED_MD_EN
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Out_Valid <= 1'b0;
      if (state == S_IDLE) begin
        if (In_Valid) begin
          if (dec_mul || dec_div) begin
            cnt  <= CNT_W'(WIDTH);
            hi_q <= '0;
            lo_q <= dec_mul ? ld_b : ld_a;
            md_q <= dec_mul ? ld_a : ld_b;
`ifdef ALU_SIGNED_MD_EN
            sgn_q <= dec_sgn;
            neg_q <= Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1];
            neg_r <= Operand_A[WIDTH-1];
`endif
          end else begin
            Out_Valid <= 1'b1;
            Result    <= dec_res;
            Zero      <= (dec_res == '0);
            Error     <= dec_err;
          end
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          hi_q      <= fin_hi;
          lo_q      <= fin_lo;
          Out_Valid <= 1'b1;
          Result    <= fin_lo;
          Zero      <= (fin_lo == '0);
          Error     <= 1'b0;
        end else begin
          hi_q <= step_hi;
          lo_q <= step_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         In_Valid = 1'b0;
  logic [1:0]   ALU_OP = '0;
  logic [5:0]   Function_Field = '0;
  logic [W-1:0] Operand_A = '0, Operand_B = '0;
  logic [W-1:0] Result;
  logic         Zero, Out_Valid, Busy, Error;

  int n_cmp = 0;
  int n_bad = 0;

  // reference HI/LO
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .ALU_OP(ALU_OP),
    .Function_Field(Function_Field), .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Result(Result), .Zero(Zero), .Out_Valid(Out_Valid), .Busy(Busy), .Error(Error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on full-width integers.
  task automatic model(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit err, output int lat);
    logic [63:0] p;
    longint sa, sb, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; err = 1'b0; lat = 1;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin
        case (fn)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
          6'h10: r = m_hi;
          6'h12: r = m_lo;
          6'h19: begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W + 1;
          end
          6'h1b: begin
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
            r = m_lo; lat = W + 1;
          end
`ifdef ALU_SIGNED_MD_EN
          6'h18: begin
            p = sa * sb;
            m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W + 1;
          end
          6'h1a: begin
            if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin
              q = sa / sb; rm = sa % sb;
              m_lo = q[31:0]; m_hi = rm[31:0];
            end
            r = m_lo; lat = W + 1;
          end
`endif
          default: err = 1'b1;
        endcase
      end
      default: err = 1'b1;
    endcase
  endtask

  // Issue one op (assumes we sit at a negedge), wait for Out_Valid, check.
  // With noise set, random In_Valid pulses are driven while Busy.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input bit noise,
                       output logic [31:0] res);
    logic [31:0] er;
    bit ee, got;
    int el, lat, bcnt;
    model(op, fn, a, b, er, ee, el);
    ALU_OP = op; Function_Field = fn; Operand_A = a; Operand_B = b; In_Valid = 1'b1;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (Out_Valid) got = 1'b1;
      else begin
        if (Busy) bcnt++;
        if (noise && Busy) begin
          In_Valid = 1'($urandom);
          ALU_OP = 2'($urandom);
          Function_Field = 6'($urandom);
          Operand_A = $urandom; Operand_B = $urandom;
        end else In_Valid = 1'b0;
      end
    end
    In_Valid = 1'b0;
    res = Result;
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(el - 1));
    chk({tag, " busy_at_done"}, 64'(Busy), 64'd0);
    chk({tag, " result"}, 64'(Result), 64'(er));
    chk({tag, " zero"}, 64'(Zero), 64'(er == 0));
    chk({tag, " error"}, 64'(Error), 64'(ee));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] tbl [16] = '{8'h00, 8'h40, 8'hA0, 8'hA2, 8'hA4, 8'hA5, 8'hA7, 8'hAA,
                           8'h90, 8'h92, 8'h99, 8'h9B, 8'h98, 8'h9A, 8'hC0, 8'hBF};

  initial begin
    logic [31:0] r;
    logic [7:0]  e;
    int ov;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst result", 64'(Result), 64'd0);
    chk("rst zero", 64'(Zero), 64'd1);
    chk("rst out_valid", 64'(Out_Valid), 64'd0);
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst error", 64'(Error), 64'd0);
    rst = 1'b0;
    do_op("rst mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    do_op("rst mflo", 2'd2, 6'h12, 0, 0, 0, r);

    // 1
    do_op("add", 2'd2, 6'h20, 5, 7, 0, r);
    chk("add 5+7", 64'(r), 64'd12);
    // 2
    do_op("beq sub", 2'd1, 6'h00, 32'h1234, 32'h1234, 0, r);
    chk("beq sub zero", 64'(Zero), 64'd1);
    do_op("slt ovf", 2'd2, 6'h2a, 32'h8000_0000, 1, 0, r);
    chk("slt ovf value", 64'(r), 64'd1);
    // 3
    do_op("multu", 2'd2, 6'h19, 32'hFFFF_FFFF, 2, 1, r);
    chk("multu lo", 64'(r), 64'hFFFF_FFFE);
    do_op("multu mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("multu hi", 64'(r), 64'd1);
    // 4 (each do_op issues on the previous op's Out_Valid cycle)
    do_op("divu", 2'd2, 6'h1b, 100, 7, 1, r);
    chk("divu q", 64'(r), 64'd14);
    do_op("divu mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("divu rem", 64'(r), 64'd2);
    do_op("divu0", 2'd2, 6'h1b, 100, 0, 0, r);
    chk("divu0 q", 64'(r), 64'hFFFF_FFFF);
    do_op("divu0 mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("divu0 rem", 64'(r), 64'd100);
    // 5
    do_op("aluop11", 2'd3, 6'h20, 3, 4, 0, r);
    do_op("funct3f", 2'd2, 6'h3f, 3, 4, 0, r);
    do_op("illegal mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    do_op("illegal mflo", 2'd2, 6'h12, 0, 0, 0, r);

    // abort multu mid-flight with reset
    do_op("pre-abort", 2'd2, 6'h19, 32'h1234_5678, 32'h9abc_def0, 0, r);
    ALU_OP = 2'd2; Function_Field = 6'h19; Operand_A = 32'hFFFF_FFFF; Operand_B = 32'hFFFF_FFFF;
    In_Valid = 1'b1;
    @(negedge clk);
    In_Valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort busy before", 64'(Busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort busy", 64'(Busy), 64'd0);
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      if (Out_Valid) ov++;
      @(negedge clk);
    end
    chk("abort no out_valid", 64'(ov), 64'd0);
    do_op("abort mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("abort hi", 64'(r), 64'd0);
    do_op("abort mflo", 2'd2, 6'h12, 0, 0, 0, r);
    chk("abort lo", 64'(r), 64'd0);

    // 6
`ifdef ALU_SIGNED_MD_EN
    do_op("mult", 2'd2, 6'h18, 32'hFFFF_FFFD, 4, 0, r);
    chk("mult lo", 64'(r), 64'hFFFF_FFF4);
    do_op("mult mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("mult hi", 64'(r), 64'hFFFF_FFFF);
    do_op("div", 2'd2, 6'h1a, 32'hFFFF_FFF9, 2, 0, r);
    chk("div q", 64'(r), 64'hFFFF_FFFD);
    do_op("div mfhi", 2'd2, 6'h10, 0, 0, 0, r);
    chk("div rem", 64'(r), 64'hFFFF_FFFF);
`else
    do_op("mult off", 2'd2, 6'h18, 32'hFFFF_FFFD, 4, 0, r);
    chk("mult off error", 64'(Error), 64'd1);
`endif

    // randomized ops against the reference
    for (int i = 0; i < 50; i++) begin
      e = tbl[$urandom_range(0, 15)];
      do_op("rand", e[7:6], e[5:0], rnd_val(), rnd_val(), 1'($urandom), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
